// File: rtl/ahb_sram_pkg.sv
// Shared encodings for the AHB-Lite SRAM front-end: bus codes, FSM states, byte masks.
package ahb_sram_pkg;

    // AHB transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    // AHB transfer sizes handled by this slave
    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Byte-lane masks before shifting by the low address bits
    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Controller state: WR/RD/RDSTALL/ERRx name the data phase in progress
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RDSTALL,
        ST_ERR1,
        ST_ERR2
    } state_t;

endpackage

// File: rtl/ahb_sram_ctrl_byte_lane_decode.sv
// Byte-lane decode: turns HSIZE and HADDR[1:0] into a write mask and an illegal flag.
module ahb_byte_lane_decode
    import ahb_sram_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask,
    output logic       illegal
);

    // Sizes above a word, and misaligned half/word transfers, are illegal and get no lanes
    always_comb begin
        mask    = MASK_NONE;
        illegal = 1'b0;
        case (size)
            HSIZE_BYTE: mask = MASK_BYTE << addr_lo;
            HSIZE_HALF: begin
                illegal = addr_lo[0];
                mask    = addr_lo[0] ? MASK_NONE : (MASK_HALF << addr_lo);
            end
            HSIZE_WORD: begin
                illegal = |addr_lo;
                mask    = (|addr_lo) ? MASK_NONE : MASK_WORD;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave front-end for a single-port 32-bit SRAM macro.
// Reads issue in the address phase (zero wait); writes issue in the data phase
// from latched address/mask. A read arriving while a write owns the RAM port is
// delayed one cycle (RDSTALL). Illegal size/alignment yields a two-cycle ERROR.
//
// Handshake: a transfer is taken when HSEL & HREADY & HTRANS[1]; a data phase
// completes on the cycle HREADYOUT=1. HREADYOUT drops only in RDSTALL and ERR1.
module ahb_sram_ctrl
    import ahb_sram_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic          HREADY,
    input  logic [31:0]   HWDATA,
    output logic [31:0]   HRDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic          RAM_EN,
    output logic [3:0]    RAM_WE,
    output logic [AW-1:0] RAM_A,
    output logic [31:0]   RAM_Di,
    input  logic [31:0]   RAM_Do
);

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_mask;
    logic [AW-1:0] rd_addr;

    logic          acc;
    logic          open_slot;
    logic          take;
    logic          rd_now;
    logic [3:0]    lane_mask;
    logic          illegal;
    logic [AW-1:0] haddr_word;

    // Upper address bits and the SEQ/NONSEQ distinction do not affect this slave
    logic unused_ok;
    assign unused_ok = ^{HADDR[31:AW+2], HTRANS[0]};

    assign acc        = HSEL & HREADY & HTRANS[1];
    assign haddr_word = HADDR[AW+1:2];
    // States in which a new address phase can legally be accepted
    assign open_slot  = (state != ST_RDSTALL) && (state != ST_ERR1);
    assign take       = acc & ~illegal & open_slot;
    // A read can use the RAM immediately unless the write data phase owns the port
    assign rd_now     = take & ~HWRITE & (state != ST_WR);

    assign HRDATA = RAM_Do;
    assign RAM_Di = HWDATA;

    ahb_byte_lane_decode u_lane_decode (
        .size    (HSIZE),
        .addr_lo (HADDR[1:0]),
        .mask    (lane_mask),
        .illegal (illegal)
    );

    // State register with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch write address/mask for the data phase and the read address for a stalled read
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_addr <= '0;
            wr_mask <= MASK_NONE;
            rd_addr <= '0;
        end else if (take) begin
            if (HWRITE) begin
                wr_addr <= haddr_word;
                wr_mask <= lane_mask;
            end else if (state == ST_WR) begin
                rd_addr <= haddr_word;
            end
        end
    end

    // Next-state decode: stall and error sequences run to completion, otherwise follow the new transfer
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_RDSTALL: next_state = ST_RD;
            ST_ERR1:    next_state = ST_ERR2;
            default: begin
                if (acc) begin
                    if (illegal) begin
                        next_state = ST_ERR1;
                    end else if (HWRITE) begin
                        next_state = ST_WR;
                    end else if (state == ST_WR) begin
                        next_state = ST_RDSTALL;
                    end else begin
                        next_state = ST_RD;
                    end
                end
            end
        endcase
    end

    // Output decode: RAM and bus response; reset masks every RAM strobe so a pending write is dropped
    always_comb begin
        RAM_EN    = 1'b0;
        RAM_WE    = MASK_NONE;
        RAM_A     = haddr_word;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        if (!RST) begin
            case (state)
                ST_WR: begin
                    RAM_EN = 1'b1;
                    RAM_WE = wr_mask;
                    RAM_A  = wr_addr;
                end
                ST_RDSTALL: begin
                    RAM_EN    = 1'b1;
                    RAM_A     = rd_addr;
                    HREADYOUT = 1'b0;
                end
                ST_ERR1: begin
                    HREADYOUT = 1'b0;
                    HRESP     = 1'b1;
                end
                ST_ERR2: begin
                    HRESP = 1'b1;
                end
                default: ;
            endcase
            if (rd_now) begin
                RAM_EN = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench for ahb_sram_ctrl with a behavioural SRAM and a per-cycle expectation queue.
module tb_ahb_sram_ctrl;
    import ahb_sram_pkg::*;

    localparam int AW = 11;

    logic          clk;
    logic          RST;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic          HREADY;
    logic [31:0]   HWDATA;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic          RAM_EN;
    logic [3:0]    RAM_WE;
    logic [AW-1:0] RAM_A;
    logic [31:0]   RAM_Di;
    logic [31:0]   RAM_Do;

    // Single-slave bus: the ready seen by everyone is this slave's ready
    assign HREADY = HREADYOUT;

    ahb_sram_ctrl #(.AW(AW)) dut (
        .CLK       (clk),
        .RST       (RST),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .RAM_EN    (RAM_EN),
        .RAM_WE    (RAM_WE),
        .RAM_A     (RAM_A),
        .RAM_Di    (RAM_Di),
        .RAM_Do    (RAM_Do)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM model (preloaded 0xA500_0000 | index) ----------------
    logic [31:0] mem [0:(1<<AW)-1];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'hA500_0000 | i;
            mem_ready <= 1'b1;
        end else if (RAM_EN) begin
            for (int b = 0; b < 4; b++)
                if (RAM_WE[b]) mem[RAM_A][8*b +: 8] <= RAM_Di[8*b +: 8];
            if (RAM_WE == 4'b0000) RAM_Do <= mem[RAM_A];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        string       name;
        logic        rdy;
        logic        resp;
        logic        en;
        logic [3:0]  we;
        logic        chk_a;
        logic [10:0] a;
        logic        chk_d;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic exp_push(input string name, input logic rdy, input logic resp, input logic en,
                            input logic [3:0] we, input logic chk_a, input logic [10:0] a,
                            input logic chk_d, input logic [31:0] d);
        exp_t e;
        e.cyc = cyc; e.name = name; e.rdy = rdy; e.resp = resp; e.en = en; e.we = we;
        e.chk_a = chk_a; e.a = a; e.chk_d = chk_d; e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: mid-cycle, compare the DUT against every expectation due this cycle
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
                end else begin
                    check({e.name, ".hreadyout"}, {31'd0, HREADYOUT}, {31'd0, e.rdy});
                    check({e.name, ".hresp"},     {31'd0, HRESP},     {31'd0, e.resp});
                    check({e.name, ".ram_en"},    {31'd0, RAM_EN},    {31'd0, e.en});
                    check({e.name, ".ram_we"},    {28'd0, RAM_WE},    {28'd0, e.we});
                    if (e.chk_a) check({e.name, ".ram_a"}, {21'd0, RAM_A}, {21'd0, e.a});
                    if (e.chk_d) check({e.name, ".hrdata"}, HRDATA, e.d);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drv(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd);
        HSEL = sel; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = addr; HWDATA = wd;
    endtask

    task automatic idle(input logic [31:0] wd);
        drv(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0, wd);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        idle(32'h0);
        tick();
        tick();
        // Reset cycle with a legal read presented: no RAM access, OKAY/ready
        drv(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
        exp_push("reset", 1, 0, 0, 4'h0, 0, 11'h0, 0, 32'h0);
        tick();
        RST = 1'b0;

        // Test 1: word write then back-to-back read of the same word (one wait state)
        drv(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h0);
        exp_push("t1_wr_addr", 1, 0, 0, 4'h0, 0, 11'h0, 0, 32'h0);
        tick();
        drv(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
        exp_push("t1_wr_data", 1, 0, 1, 4'hF, 1, 11'h004, 0, 32'h0);
        tick();
        idle(32'h0);
        exp_push("t1_rd_stall", 0, 0, 1, 4'h0, 1, 11'h004, 0, 32'h0);
        tick();
        // Test 2 address phase overlaps test 1 read data phase
        drv(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h12, 32'h0);
        exp_push("t1_rd_data", 1, 0, 0, 4'h0, 0, 11'h0, 1, 32'hDEADBEEF);
        tick();

        // Test 2: byte write into lane 2, then a non-adjacent read
        idle(32'h00AB0000);
        exp_push("t2_wr_data", 1, 0, 1, 4'b0100, 1, 11'h004, 0, 32'h0);
        tick();
        drv(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
        exp_push("t2_rd_addr", 1, 0, 1, 4'h0, 1, 11'h004, 0, 32'h0);
        tick();
        idle(32'h0);
        exp_push("t2_rd_data", 1, 0, 0, 4'h0, 0, 11'h0, 1, 32'hDEABBEEF);
        tick();

        // Test 3: misaligned half write -> two-cycle ERROR, then OKAY
        drv(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h1001, 32'h0);
        exp_push("t3_addr", 1, 0, 0, 4'h0, 0, 11'h0, 0, 32'h0);
        tick();
        idle(32'h1234);
        exp_push("t3_err1", 0, 1, 0, 4'h0, 0, 11'h0, 0, 32'h0);
        tick();
        exp_push("t3_err2", 1, 1, 0, 4'h0, 0, 11'h0, 0, 32'h0);
        tick();
        exp_push("t3_idle", 1, 0, 0, 4'h0, 0, 11'h0, 0, 32'h0);
        tick();

        // Test 4: four pipelined word reads at the top of memory (bank 1)
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                drv(1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, HSIZE_WORD,
                    32'h1FF0 + 32'(4 * i), 32'h0);
                exp_push($sformatf("t4_rd%0d", i), 1, 0, 1, 4'h0, 1, 11'h7FC + 11'(i),
                         (i > 0), 32'hA50007FC + 32'(i) - 32'd1);
            end else begin
                idle(32'h0);
                exp_push("t4_rd_last", 1, 0, 0, 4'h0, 0, 11'h0, 1, 32'hA50007FF);
            end
            tick();
        end

        // Test 5: HSIZE=3 read -> ERROR, no RAM access
        drv(1'b1, HTRANS_NONSEQ, 1'b0, 3'd3, 32'h20, 32'h0);
        exp_push("t5_addr", 1, 0, 0, 4'h0, 0, 11'h0, 0, 32'h0);
        tick();
        idle(32'h0);
        exp_push("t5_err1", 0, 1, 0, 4'h0, 0, 11'h0, 0, 32'h0);
        tick();
        exp_push("t5_err2", 1, 1, 0, 4'h0, 0, 11'h0, 0, 32'h0);
        tick();
        exp_push("t5_idle", 1, 0, 0, 4'h0, 0, 11'h0, 0, 32'h0);
        tick();

        // Test 6: reset during the write data phase drops the write
        drv(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40, 32'h0);
        exp_push("t6_wr_addr", 1, 0, 0, 4'h0, 0, 11'h0, 0, 32'h0);
        tick();
        RST = 1'b1;
        idle(32'h12345678);
        exp_push("t6_rst_wr", 1, 0, 0, 4'h0, 0, 11'h0, 0, 32'h0);
        tick();
        RST = 1'b0;
        drv(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40, 32'h0);
        exp_push("t6_post_rst", 1, 0, 1, 4'h0, 1, 11'h010, 0, 32'h0);
        tick();
        idle(32'h0);
        exp_push("t6_rd_old", 1, 0, 0, 4'h0, 0, 11'h0, 1, 32'hA5000010);
        tick();

        // Test 7: back-to-back writes, then a colliding read and a following read
        drv(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h1FFC, 32'h0);
        exp_push("t7_wr0_addr", 1, 0, 0, 4'h0, 0, 11'h0, 0, 32'h0);
        tick();
        drv(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h0002, 32'hCAFEF00D);
        exp_push("t7_wr0_data", 1, 0, 1, 4'hF, 1, 11'h7FF, 0, 32'h0);
        tick();
        drv(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h1FFC, 32'hBEEF0000);
        exp_push("t7_wr1_data", 1, 0, 1, 4'b1100, 1, 11'h000, 0, 32'h0);
        tick();
        drv(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000, 32'h0);
        exp_push("t7_rd_stall", 0, 0, 1, 4'h0, 1, 11'h7FF, 0, 32'h0);
        tick();
        exp_push("t7_rd0_data", 1, 0, 1, 4'h0, 1, 11'h000, 1, 32'hCAFEF00D);
        tick();
        idle(32'h0);
        exp_push("t7_rd1_data", 1, 0, 0, 4'h0, 0, 11'h0, 1, 32'hBEEF0000);
        tick();

        // Drain: every expectation must have been consumed
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
